phase_monitor: RTL and testbench
================================

Name: phase_monitor

Overview:
- Receiving end of the two-phase non-overlapping clock scheme driven by the core's phase generator.
- Samples the phase lines PH1 and PH2 in the CLK domain and checks that they follow the legal order PH1, gap, PH2, gap.
- Outputs single-cycle phase strobes, an 8-state machine-cycle counter (CYC) and lock/error status for the 5401 sequencer and the debug port.

Parameters:
- LOCK_PERIODS, 4: consecutive clean PH1→PH2 periods required before LOCK asserts.
- TIMEOUT, 8: max CLK cycles any FSM state may persist before a missing-phase error (range 2..255).
- CYC_W, 3: width of CYC; wraps at 2^CYC_W.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous reset, active-low.
- PH1  in  1  phase-1 line, synchronous to CLK.
- PH2  in  1  phase-2 line, synchronous to CLK.
- ERR_CLR  in  1  synchronous clear of sticky errors and ERR_CNT.
- PH1_EN  out  1  one-cycle strobe on a legal PH1 rising edge.
- PH2_EN  out  1  one-cycle strobe on a legal PH2 rising edge.
- CYC  out  CYC_W  machine-cycle index.
- LOCK  out  1  phase sequence verified.
- OVLP_ERR  out  1  sticky: PH1 and PH2 were high together.
- ORDER_ERR  out  1  sticky: phase rose out of order.
- MISS_ERR  out  1  sticky: timeout expired.
- ERR_CNT  out  4  saturating count of error events.

Behaviour:
- RST low (async): every output 0, FSM = SEEK, period count 0, timer 0, input registers 0.
- PH1/PH2 registered once (p1_q, p2_q). Rise = current input high and registered copy low. PH1_EN/PH2_EN are registered, so each strobe appears 1 CLK after the input edge.
- FSM states:
  - SEEK: wait for PH1 rise → P1. PH2 activity ignored. No timeout in SEEK.
  - P1: PH1 high; PH1 fall → GAP1.
  - GAP1: PH2 rise → P2; PH1 rise → ORDER error.
  - P2: PH2 high; PH2 fall → GAP2.
  - GAP2: PH1 rise → P1 and completes a period; PH2 rise → ORDER error.
- Timer: reset on every state change. Counts CLK cycles in P1, GAP1, P2, GAP2. Reaching TIMEOUT raises a MISS error.
- Overlap: PH1 and PH2 both high in the same sample, in any state except SEEK, raises an OVLP error. It takes priority over ORDER and MISS in the same cycle.
- Any error event:
  - sets the matching sticky flag;
  - increments ERR_CNT by 1, saturating at 15;
  - clears LOCK and the period count, and sets CYC to 0;
  - sends the FSM to SEEK next cycle;
  - suppresses PH1_EN/PH2_EN for that edge.
- Strobes: PH1_EN on the SEEK→P1 and GAP2→P1 transitions; PH2_EN on GAP1→P2. Strobes fire whether or not LOCK is set.
- Lock:
  - Period count increments on each GAP2→P1 transition and saturates at LOCK_PERIODS.
  - LOCK asserts in the cycle after the count reaches LOCK_PERIODS. It deasserts only on an error or reset.
- CYC: increments (mod 2^CYC_W) on each GAP2→P1 transition while LOCK is already 1. The first period after lock leaves CYC at 0.
- ERR_CLR: clears the sticky flags and ERR_CNT. LOCK and FSM are unaffected. If an error occurs in the same cycle, the error wins: flag set, ERR_CNT = 1.
- Reset mid-operation: immediate return to the reset values. Lock must be regained with LOCK_PERIODS fresh periods.

Decomposition:
- Shared package (core_pkg):
  - FSM state encoding (SEEK, P1, GAP1, P2, GAP2; 3 bits).
  - ERR_CNT width and saturation constant.
  - Default LOCK_PERIODS and TIMEOUT.
- One sub-module: phase_edge. It holds the input register plus rise/fall detection for a single line and is instantiated twice.
- Timer, FSM and counters stay in the top module. Total about 200 lines.

Test Plan:
- Clean drive from the phase generator (PH1 1-cycle pulse, 1 gap, PH2 1-cycle pulse, 1 gap):
  - PH1_EN/PH2_EN pulse 1 CLK after each rise;
  - LOCK rises after the 4th GAP2→P1;
  - CYC counts 0..7 and wraps to 0 after 8 further locked periods;
  - all errors remain 0.
- Force PH2 high during P1 while locked → OVLP_ERR=1, ERR_CNT=1, LOCK=0, CYC=0, FSM in SEEK; 4 clean periods then restore LOCK.
- PH1 pulses twice with no PH2 between → ORDER_ERR=1 on the second rise, no PH1_EN for that edge, ERR_CNT=1.
- Hold PH1 low after a PH2 fall for 8 cycles → MISS_ERR=1 on the 8th cycle in GAP2; repeat 20 error events → ERR_CNT saturates at 15.
- ERR_CLR pulsed in the same cycle as an overlap error → OVLP_ERR=1 and ERR_CNT=1; pulsed alone → all sticky flags 0, ERR_CNT=0, LOCK unchanged.
- RST driven low asynchronously mid-P2 while locked → all outputs 0 immediately with no CLK edge; after release, the first PH1 rise gives PH1_EN and LOCK stays 0 until 4 clean periods.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the phase monitor: FSM encoding, error counter
// sizing and default timing parameters.
package core_pkg;

    // Phase-sequence FSM encoding (3 bits, legacy-compatible constants).
    localparam logic [2:0] ST_SEEK = 3'd0;
    localparam logic [2:0] ST_P1   = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_P2   = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;

    // Error event counter: 4 bits, saturating.
    localparam int                   ERR_CNT_W   = 4;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'd15;

    // Default timing parameters.
    localparam int DEFAULT_LOCK_PERIODS = 4;
    localparam int DEFAULT_TIMEOUT      = 8;

    // Saturating increment of the error counter.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/phase_edge.sv
// Input register plus rise/fall detection for one phase line. The line is
// already synchronous to the clock, so a single register suffices.
module phase_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ph,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    // Hold the previous sample of the phase line.
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= 1'b0;
        else          r_q <= i_ph;
    end

    assign o_rise = i_ph & ~r_q;
    assign o_fall = ~i_ph & r_q;

endmodule

// File: rtl/phase_monitor.sv
// Receiver for the two-phase non-overlapping clock. Tracks the legal order
// PH1, gap, PH2, gap; emits phase strobes, a machine-cycle index and
// lock/error status.
module phase_monitor
    import core_pkg::*;
#(
    parameter int LOCK_PERIODS = DEFAULT_LOCK_PERIODS,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT,   // 2..255
    parameter int CYC_W        = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PH1,
    input  logic                 PH2,
    input  logic                 ERR_CLR,
    output logic                 PH1_EN,
    output logic                 PH2_EN,
    output logic [CYC_W-1:0]     CYC,
    output logic                 LOCK,
    output logic                 OVLP_ERR,
    output logic                 ORDER_ERR,
    output logic                 MISS_ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int                TIMER_W    = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam int                PCNT_W     = $clog2(LOCK_PERIODS + 1);
    localparam logic [PCNT_W-1:0] PCNT_MAX   = PCNT_W'(LOCK_PERIODS);

    logic                 w_ph1_rise, w_ph1_fall, w_ph2_rise, w_ph2_fall;
    logic [2:0]           r_state, w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [PCNT_W-1:0]    r_pcnt;
    logic [CYC_W-1:0]     r_cyc;
    logic                 r_lock, r_ph1_en, r_ph2_en;
    logic                 r_ovlp, r_order, r_miss;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_strobe1, w_strobe2, w_period, w_order;
    logic                 w_err_ovlp, w_err_order, w_err_miss, w_err_any;

    phase_edge u_edge_ph1 (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_ph    (PH1),
        .o_rise  (w_ph1_rise),
        .o_fall  (w_ph1_fall)
    );

    phase_edge u_edge_ph2 (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_ph    (PH2),
        .o_rise  (w_ph2_rise),
        .o_fall  (w_ph2_fall)
    );

    // Next-state decode, error classification (overlap > order > miss).
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_strobe1   = 1'b0;
        w_strobe2   = 1'b0;
        w_period    = 1'b0;
        w_order     = 1'b0;
        case (r_state)
            ST_SEEK: if (w_ph1_rise) begin
                w_state_nxt = ST_P1;
                w_strobe1   = 1'b1;
            end
            ST_P1: if (w_ph1_fall) w_state_nxt = ST_GAP1;
            ST_GAP1: begin
                if (w_ph2_rise) begin
                    w_state_nxt = ST_P2;
                    w_strobe2   = 1'b1;
                end else if (w_ph1_rise) begin
                    w_order = 1'b1;
                end
            end
            ST_P2: if (w_ph2_fall) w_state_nxt = ST_GAP2;
            ST_GAP2: begin
                if (w_ph1_rise) begin
                    w_state_nxt = ST_P1;
                    w_strobe1   = 1'b1;
                    w_period    = 1'b1;
                end else if (w_ph2_rise) begin
                    w_order = 1'b1;
                end
            end
            default: w_state_nxt = ST_SEEK;
        endcase

        w_err_ovlp  = (r_state != ST_SEEK) && PH1 && PH2;
        w_err_order = w_order && !w_err_ovlp;
        w_err_miss  = (r_state != ST_SEEK) && (w_state_nxt == r_state) &&
                      (r_timer == TIMER_LAST) && !w_err_ovlp && !w_order;
        w_err_any   = w_err_ovlp || w_err_order || w_err_miss;

        // An error aborts the edge: no strobe, no period credit, back to SEEK.
        if (w_err_any) begin
            w_state_nxt = ST_SEEK;
            w_strobe1   = 1'b0;
            w_strobe2   = 1'b0;
            w_period    = 1'b0;
        end
    end

    // FSM state and dwell timer; the timer restarts on every state change.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_SEEK;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)  r_timer <= '0;
            else if (r_state != ST_SEEK) r_timer <= r_timer + TIMER_W'(1);
        end
    end

    // Registered phase strobes, one cycle after the sampled rising edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ph1_en <= 1'b0;
            r_ph2_en <= 1'b0;
        end else begin
            r_ph1_en <= w_strobe1;
            r_ph2_en <= w_strobe2;
        end
    end

    // Period counting, lock and machine-cycle index; any error drops lock.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pcnt <= '0;
            r_lock <= 1'b0;
            r_cyc  <= '0;
        end else if (w_err_any) begin
            r_pcnt <= '0;
            r_lock <= 1'b0;
            r_cyc  <= '0;
        end else begin
            if (w_period) begin
                if (r_pcnt != PCNT_MAX) r_pcnt <= r_pcnt + PCNT_W'(1);
                // CYC only advances once lock was already established.
                if (r_lock)             r_cyc  <= r_cyc + CYC_W'(1);
            end
            if (r_pcnt == PCNT_MAX) r_lock <= 1'b1;
        end
    end

    // Sticky error flags and saturating event count; a new error beats ERR_CLR.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ovlp    <= 1'b0;
            r_order   <= 1'b0;
            r_miss    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ovlp  <= (r_ovlp  && !ERR_CLR) || w_err_ovlp;
            r_order <= (r_order && !ERR_CLR) || w_err_order;
            r_miss  <= (r_miss  && !ERR_CLR) || w_err_miss;
            if (w_err_any)
                r_err_cnt <= ERR_CLR ? ERR_CNT_W'(1) : err_cnt_inc(r_err_cnt);
            else if (ERR_CLR)
                r_err_cnt <= '0;
        end
    end

    assign PH1_EN    = r_ph1_en;
    assign PH2_EN    = r_ph2_en;
    assign CYC       = r_cyc;
    assign LOCK      = r_lock;
    assign OVLP_ERR  = r_ovlp;
    assign ORDER_ERR = r_order;
    assign MISS_ERR  = r_miss;
    assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor: clean lock-up and CYC wrap, overlap,
// order and timeout errors, error-count saturation, ERR_CLR interaction and
// asynchronous reset while locked.
module tb_phase_monitor;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       PH1 = 1'b0;
    logic       PH2 = 1'b0;
    logic       ERR_CLR = 1'b0;
    logic       PH1_EN, PH2_EN, LOCK, OVLP_ERR, ORDER_ERR, MISS_ERR;
    logic [2:0] CYC;
    logic [3:0] ERR_CNT;

    int n_total = 0;
    int n_bad   = 0;

    phase_monitor #(.LOCK_PERIODS(4), .TIMEOUT(8), .CYC_W(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PH1       (PH1),
        .PH2       (PH2),
        .ERR_CLR   (ERR_CLR),
        .PH1_EN    (PH1_EN),
        .PH2_EN    (PH2_EN),
        .CYC       (CYC),
        .LOCK      (LOCK),
        .OVLP_ERR  (OVLP_ERR),
        .ORDER_ERR (ORDER_ERR),
        .MISS_ERR  (MISS_ERR),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one sample, let the DUT take it, then settle 1 time unit past the edge.
    task automatic tick(input logic p1, input logic p2, input logic clr);
        PH1     = p1;
        PH2     = p2;
        ERR_CLR = clr;
        @(posedge CLK);
        #1;
        ERR_CLR = 1'b0;
    endtask

    // PH1 pulse, gap, PH2 pulse, gap with strobe checks.
    task automatic clean_period();
        tick(1'b1, 1'b0, 1'b0);
        check("ph1_en", PH1_EN, 1);
        tick(1'b0, 1'b0, 1'b0);
        check("ph1_en_off", PH1_EN, 0);
        tick(1'b0, 1'b1, 1'b0);
        check("ph2_en", PH2_EN, 1);
        tick(1'b0, 1'b0, 1'b0);
        check("ph2_en_off", PH2_EN, 0);
    endtask

    // From SEEK: one entry pulse plus four GAP2->P1 periods; LOCK rises the
    // cycle after the fourth GAP2->P1. Ends in GAP2, locked, CYC=0.
    task automatic acquire_lock(input string tag);
        for (int i = 0; i < 4; i++) begin
            clean_period();
            check({tag, "_lock_low"}, LOCK, 0);
        end
        tick(1'b1, 1'b0, 1'b0);
        check({tag, "_ph1_en_4th"}, PH1_EN, 1);
        check({tag, "_lock_not_yet"}, LOCK, 0);
        tick(1'b0, 1'b0, 1'b0);
        check({tag, "_lock_up"}, LOCK, 1);
        check({tag, "_cyc0"}, CYC, 0);
        tick(1'b0, 1'b1, 1'b0);
        check({tag, "_ph2_en"}, PH2_EN, 1);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("rst_outputs", {PH1_EN, PH2_EN, CYC, LOCK, OVLP_ERR, ORDER_ERR, MISS_ERR, ERR_CNT}, 0);
        @(negedge CLK);
        RST = 1'b1;

        // Clean drive: lock, then CYC 1..7 and wrap to 0 over 8 locked periods.
        acquire_lock("clean");
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("cyc_count", CYC, k % 8);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        check("clean_errs", {OVLP_ERR, ORDER_ERR, MISS_ERR, ERR_CNT}, 0);
        check("clean_lock_held", LOCK, 1);

        // Overlap during P1 while locked.
        tick(1'b1, 1'b0, 1'b0);
        check("pre_ovlp_cyc", CYC, 1);
        tick(1'b1, 1'b1, 1'b0);
        check("ovlp_flag", OVLP_ERR, 1);
        check("ovlp_cnt", ERR_CNT, 1);
        check("ovlp_lock", LOCK, 0);
        check("ovlp_cyc", CYC, 0);
        check("ovlp_no_ph2_en", PH2_EN, 0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);   // SEEK ignores PH2
        check("seek_ph2_ignored", PH2_EN, 0);
        check("seek_no_err", ERR_CNT, 1);
        tick(1'b0, 1'b0, 1'b0);
        acquire_lock("relock");

        // ERR_CLR alone: flags and count cleared, LOCK untouched.
        tick(1'b0, 1'b0, 1'b1);
        check("clr_flags", {OVLP_ERR, ORDER_ERR, MISS_ERR}, 0);
        check("clr_cnt", ERR_CNT, 0);
        check("clr_lock_kept", LOCK, 1);

        // Two PH1 pulses with no PH2 between.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("order_flag", ORDER_ERR, 1);
        check("order_no_ph1_en", PH1_EN, 0);
        check("order_cnt", ERR_CNT, 1);
        check("order_lock", LOCK, 0);
        tick(1'b0, 1'b0, 1'b0);

        // Missing PH1 after PH2 fall: timeout on the 8th cycle in GAP2.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);   // PH2 fall -> GAP2
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0);
        check("miss_not_yet", MISS_ERR, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("miss_flag", MISS_ERR, 1);
        check("miss_cnt", ERR_CNT, 2);
        check("miss_order_sticky", ORDER_ERR, 1);

        // 18 more overlap events: count saturates at 15.
        for (int i = 1; i <= 18; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b1, 1'b0);
            check("sat_cnt", ERR_CNT, (2 + i > 15) ? 15 : 2 + i);
            tick(1'b0, 1'b0, 1'b0);
        end

        // ERR_CLR together with an overlap: the error wins.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("clr_vs_err_flags", {OVLP_ERR, ORDER_ERR, MISS_ERR}, 3'b100);
        check("clr_vs_err_cnt", ERR_CNT, 1);
        tick(1'b0, 1'b0, 1'b1);
        check("clr2_all", {OVLP_ERR, ORDER_ERR, MISS_ERR, ERR_CNT}, 0);
        check("clr2_lock", LOCK, 0);

        // Asynchronous reset mid-P2 while locked.
        acquire_lock("prerst");
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("prerst_state", {PH2_EN, LOCK, CYC}, 5'b1_1_001);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_outputs", {PH1_EN, PH2_EN, CYC, LOCK, OVLP_ERR, ORDER_ERR, MISS_ERR, ERR_CNT}, 0);
        PH2 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        acquire_lock("postrst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
